serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: parallel operands are accepted on start, added
// LSB-first through a one-bit full adder, and the sum is presented with a done strobe.
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_in_i,
  input  logic [WIDTH-1:0] b_in_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_out_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             bit_s;
  logic             carry_s;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
        else         state_d = S_IDLE;
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) state_d = S_DONE;
        else                   state_d = S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_RUN:   busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  // One full-adder slice per RUN cycle; results publish only on the final bit
  always_comb begin
    bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_s  = maj3(a_sh_q[0], b_sh_q[0], carry_q);
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_sh_d  = a_in_i;
          b_sh_d  = b_in_i;
          carry_d = cin_i;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_q;
        end
      end
      S_RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = {bit_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = carry_s;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_PENULT) begin
          cmsb_d = carry_s;
        end else begin
          cmsb_d = cmsb_q;
        end
        if (cnt_q == CNT_LAST) begin
          sum_d  = {bit_s, sum_sh_q[WIDTH-1:1]};
          cout_d = carry_s;
          ovf_d  = cmsb_q ^ carry_s;
          cnt_d  = {CW{1'b0}};
        end else begin
          sum_d  = sum_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      sum_sh_q <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      sum_q    <= {WIDTH{1'b0}};
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum_out_o = sum_q;
  assign cout_o    = cout_q;
  assign ovf_o     = ovf_q;

endmodule
